// File: rtl/clk_int_div_meas.sv
// Measures period, high time and divider setting of a clock derived from clk_i,
// sampled as data; one result per start handshake, held until consumed.
module clk_int_div_meas #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AVG_LOG2    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_div_i,
  input  logic                 start_valid_i,
  output logic                 start_ready_o,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic [CNT_WIDTH-1:0] div_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  localparam int unsigned AW   = CNT_WIDTH + AVG_LOG2;
  localparam int unsigned IW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned NPER = 2 ** AVG_LOG2;

  typedef enum logic [1:0] {IDLE, SYNC, MEAS, RESP} state_t;

  state_t               state;
  logic                 lvl, lvl_q, rise;
  logic [CNT_WIDTH-1:0] per_cnt, hi_cnt, tmo_cnt, timeout_q;
  logic [CNT_WIDTH-1:0] per_inc, hi_inc, per_res, hi_res;
  logic [AW-1:0]        acc_per, acc_hi, acc_per_nx, acc_hi_nx, avg_per, avg_hi;
  logic [IW-1:0]        idx;
  logic                 last, tmo_hit;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign lvl = clk_div_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= (sync_q << 1) | SYNC_STAGES'(clk_div_i);
      end
      assign lvl = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = lvl & ~lvl_q;

  always_comb begin
    per_inc    = (&per_cnt) ? per_cnt : per_cnt + 1'b1;
    hi_inc     = (lvl && !(&hi_cnt)) ? hi_cnt + 1'b1 : hi_cnt;
    acc_per_nx = acc_per + AW'(per_cnt);
    acc_hi_nx  = acc_hi + AW'(hi_cnt);
    avg_per    = acc_per_nx >> AVG_LOG2;
    avg_hi     = acc_hi_nx >> AVG_LOG2;
    // Anything left above CNT_WIDTH after the shift saturates the result.
    per_res    = (|(avg_per >> CNT_WIDTH)) ? '1 : avg_per[CNT_WIDTH-1:0];
    hi_res     = (|(avg_hi >> CNT_WIDTH)) ? '1 : avg_hi[CNT_WIDTH-1:0];
    last       = (idx == IW'(NPER - 1));
    tmo_hit    = (timeout_q != '0) && (tmo_cnt >= timeout_q - 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      lvl_q         <= 1'b0;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      tmo_cnt       <= '0;
      timeout_q     <= '0;
      acc_per       <= '0;
      acc_hi        <= '0;
      idx           <= '0;
      start_ready_o <= 1'b1;
      res_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      timeout_o     <= 1'b0;
      period_o      <= '0;
      high_o        <= '0;
      div_o         <= '0;
    end else begin
      lvl_q <= lvl;
      case (state)
        IDLE: begin
          if (start_valid_i) begin
            state         <= SYNC;
            timeout_q     <= timeout_i;
            tmo_cnt       <= '0;
            acc_per       <= '0;
            acc_hi        <= '0;
            idx           <= '0;
            start_ready_o <= 1'b0;
            busy_o        <= 1'b1;
            timeout_o     <= 1'b0;
          end
        end
        SYNC, MEAS: begin
          if (rise) begin
            per_cnt <= CNT_WIDTH'(1);
            hi_cnt  <= CNT_WIDTH'(lvl);
            tmo_cnt <= '0;
            if (state == SYNC) begin
              state <= MEAS;
            end else begin
              acc_per <= acc_per_nx;
              acc_hi  <= acc_hi_nx;
              idx     <= idx + 1'b1;
              if (last) begin
                state       <= RESP;
                res_valid_o <= 1'b1;
                busy_o      <= 1'b0;
                period_o    <= per_res;
                high_o      <= hi_res;
                div_o       <= (per_res == '0) ? '0 : per_res - 1'b1;
              end
            end
          end else if (tmo_hit) begin
            state       <= RESP;
            res_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b1;
            period_o    <= '0;
            high_o      <= '0;
            div_o       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            per_cnt <= per_inc;
            hi_cnt  <= hi_inc;
          end
        end
        RESP: begin
          if (res_ready_i) begin
            state         <= IDLE;
            res_valid_o   <= 1'b0;
            start_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_int_div_meas.sv
// Directed bench: single-period and 4-period averaging instances driven with
// hand-built divided-clock waveforms.
module tb_clk_int_div_meas;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_div = 1'b0, clk_div2 = 1'b0;
  logic        start_valid = 1'b0, start_valid2 = 1'b0;
  logic        res_ready = 1'b0, res_ready2 = 1'b0;
  logic [31:0] timeout = '0, timeout2 = '0;
  logic        start_ready, start_ready2, res_valid, res_valid2;
  logic        timeout_flag, timeout_flag2, busy, busy2;
  logic [31:0] period, period2, high, high2, div, div2;

  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  clk_int_div_meas #(.CNT_WIDTH(32), .SYNC_STAGES(2), .AVG_LOG2(0)) dut (
    .clk_i(clk), .rst_i(rst), .clk_div_i(clk_div),
    .start_valid_i(start_valid), .start_ready_o(start_ready), .timeout_i(timeout),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .period_o(period), .high_o(high), .div_o(div),
    .timeout_o(timeout_flag), .busy_o(busy)
  );

  clk_int_div_meas #(.CNT_WIDTH(32), .SYNC_STAGES(2), .AVG_LOG2(2)) dut_avg (
    .clk_i(clk), .rst_i(rst), .clk_div_i(clk_div2),
    .start_valid_i(start_valid2), .start_ready_o(start_ready2), .timeout_i(timeout2),
    .res_valid_o(res_valid2), .res_ready_i(res_ready2),
    .period_o(period2), .high_o(high2), .div_o(div2),
    .timeout_o(timeout_flag2), .busy_o(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_div(input bit sel, input logic v);
    if (sel) clk_div2 = v;
    else     clk_div  = v;
  endtask

  task automatic drive(input bit sel, input int hi, input int lo);
    repeat (hi) begin @(negedge clk); set_div(sel, 1'b1); end
    repeat (lo) begin @(negedge clk); set_div(sel, 1'b0); end
  endtask

  task automatic start(input bit sel, input logic [31:0] tmo);
    @(negedge clk);
    if (sel) begin timeout2 = tmo; start_valid2 = 1'b1; end
    else     begin timeout  = tmo; start_valid  = 1'b1; end
    @(posedge clk); #1;
    chk("start_busy", sel ? busy2 : busy, 1);
    chk("start_ready_low", sel ? start_ready2 : start_ready, 0);
    @(negedge clk);
    start_valid  = 1'b0;
    start_valid2 = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int cycles);
    cycles = 0;
    while (!(sel ? res_valid2 : res_valid) && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("res_valid_seen", sel ? res_valid2 : res_valid, 1);
  endtask

  task automatic accept(input bit sel);
    @(negedge clk);
    if (sel) res_ready2 = 1'b1;
    else     res_ready  = 1'b1;
    @(posedge clk); #1;
    chk("acc_valid_low", sel ? res_valid2 : res_valid, 0);
    chk("acc_ready_high", sel ? start_ready2 : start_ready, 1);
    chk("acc_busy_low", sel ? busy2 : busy, 0);
    @(negedge clk);
    res_ready  = 1'b0;
    res_ready2 = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_period", period, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_avg_ready", start_ready2, 1);

    // Ratio 4, 2 high / 2 low, with exact result latency
    start(0, 0);
    drive(0, 0, 3);
    drive(0, 2, 2);
    @(negedge clk); clk_div = 1'b1;
    @(posedge clk); #1; chk("lat_p0", res_valid, 0);
    @(posedge clk); #1; chk("lat_p1", res_valid, 0);
    @(posedge clk); #1; chk("lat_p2", res_valid, 1);
    chk("r4_period", period, 4);
    chk("r4_high", high, 2);
    chk("r4_div", div, 3);
    chk("r4_timeout", timeout_flag, 0);
    accept(0);
    drive(0, 0, 4);

    // Ratio 2, then 10 cycles of backpressure with a stray start request
    start(0, 0);
    drive(0, 0, 3);
    drive(0, 1, 1);
    @(negedge clk); clk_div = 1'b1;
    wait_valid(0, n);
    chk("r2_period", period, 2);
    chk("r2_high", high, 1);
    chk("r2_div", div, 1);
    @(negedge clk); start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", res_valid, 1);
      chk("bp_period", period, 2);
      chk("bp_div", div, 1);
      chk("bp_ready", start_ready, 0);
    end
    @(negedge clk); start_valid = 1'b0;
    accept(0);
    drive(0, 0, 4);

    // No edges: timeout after exactly 100 cycles
    start(0, 100);
    wait_valid(0, n);
    chk("tmo_latency", n, 100);
    chk("tmo_flag", timeout_flag, 1);
    chk("tmo_period", period, 0);
    chk("tmo_high", high, 0);
    chk("tmo_div", div, 0);
    accept(0);

    // Averaging over periods 4,4,5,5 with highs 2,2,2,3
    start(1, 0);
    drive(1, 0, 3);
    drive(1, 2, 2);
    drive(1, 2, 2);
    drive(1, 2, 3);
    drive(1, 3, 2);
    @(negedge clk); clk_div2 = 1'b1;
    wait_valid(1, n);
    chk("avg_period", period2, 4);
    chk("avg_high", high2, 2);
    chk("avg_div", div2, 3);
    chk("avg_timeout", timeout_flag2, 0);
    accept(1);

    // Reset pulse mid-measurement, then a clean ratio-3 measurement
    start(0, 0);
    drive(0, 0, 3);
    drive(0, 2, 2);
    chk("pre_rst_busy", busy, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_ready", start_ready, 1);
    @(negedge clk); rst = 1'b0; clk_div = 1'b0;
    drive(0, 0, 4);
    start(0, 0);
    drive(0, 0, 3);
    drive(0, 2, 1);
    @(negedge clk); clk_div = 1'b1;
    wait_valid(0, n);
    chk("r3_period", period, 3);
    chk("r3_high", high, 2);
    chk("r3_div", div, 2);
    chk("r3_timeout", timeout_flag, 0);
    accept(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
